dev_bridge: RTL and testbench

DEV_BRIDGE -- requirements
Module: dev_bridge

---
 rtl/dev_bridge.sv | 160 ++++++++++++++++
 tb/tb_dev_bridge.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dev_bridge.sv
// CPU-to-device bridge: two timer windows plus an interrupt controller (PEND/MASK/VEC).
// Define DEV_BRIDGE_EDGE_EN for edge-triggered pending bits; the default build latches source levels.
module dev_bridge #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PrReq,
  input  logic [31:0] PrAddr,
  input  logic        PrWe,
  input  logic [31:0] PrWD,
  output logic [31:0] PrRD,
  output logic        PrReady,
  output logic        PrErr,
  output logic [1:0]  DEV_Addr,
  output logic [31:0] DEV_WD,
  output logic        We0,
  output logic        We1,
  input  logic [31:0] RD0,
  input  logic [31:0] RD1,
  input  logic        break0,
  input  logic        break1,
  input  logic [3:0]  ext_irq,
  output logic [5:0]  HWInt
);

  localparam int unsigned NSRC = 6;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t            r_state;
  logic              r_we;
  logic              r_t0, r_t1, r_pnd, r_msk, r_vec;
  logic [NSRC-1:0]   r_pend;
  logic [NSRC-1:0]   r_mask;

  logic              w_base_hit;
  logic [3:0]        w_off;
  logic              w_t0, w_t1, w_pnd, w_msk, w_vec_hit;
  logic [NSRC-1:0]   w_src;
  logic [NSRC-1:0]   w_act;
  logic [2:0]        w_lo;
  logic [31:0]       w_vec;
  logic [31:0]       w_rdata;
  logic              w_unused;

  // Byte-lane bits are not decoded; word access only
  assign w_unused   = &{1'b0, PrAddr[1:0]};

  // Address decode on the live request, latched at acceptance
  assign w_base_hit = (PrAddr[31:6] == BASE[31:6]);
  assign w_off      = PrAddr[5:2];
  assign w_t0       = w_base_hit && (w_off[3:2] == 2'b00) && (w_off[1:0] != 2'b11);
  assign w_t1       = w_base_hit && (w_off[3:2] == 2'b01) && (w_off[1:0] != 2'b11);
  assign w_pnd      = w_base_hit && (w_off == 4'h8);
  assign w_msk      = w_base_hit && (w_off == 4'h9);
  assign w_vec_hit  = w_base_hit && (w_off == 4'hA);

  assign w_src = {ext_irq, break1, break0};
  assign w_act = r_pend & r_mask;
  assign HWInt = w_act;

  // Lowest-numbered active interrupt wins the vector
  always_comb begin
    w_lo = 3'd0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (w_act[k]) w_lo = 3'(k);
    end
  end

  assign w_vec = {|w_act, 28'd0, w_lo};

  always_comb begin
    w_rdata = 32'd0;
    if (r_t0)       w_rdata = RD0;
    else if (r_t1)  w_rdata = RD1;
    else if (r_pnd) w_rdata = {26'd0, r_pend};
    else if (r_msk) w_rdata = {26'd0, r_mask};
    else if (r_vec) w_rdata = w_vec;
  end

  // Access FSM: IDLE -> ACCESS -> DONE, completion pulse leaving DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_t0     <= 1'b0;
      r_t1     <= 1'b0;
      r_pnd    <= 1'b0;
      r_msk    <= 1'b0;
      r_vec    <= 1'b0;
      r_mask   <= '0;
      PrRD     <= 32'd0;
      PrReady  <= 1'b0;
      PrErr    <= 1'b0;
      DEV_Addr <= 2'd0;
      DEV_WD   <= 32'd0;
      We0      <= 1'b0;
      We1      <= 1'b0;
    end else begin
      We0     <= 1'b0;
      We1     <= 1'b0;
      PrReady <= 1'b0;
      PrErr   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (PrReq) begin
            r_state  <= S_ACCESS;
            r_we     <= PrWe;
            r_t0     <= w_t0;
            r_t1     <= w_t1;
            r_pnd    <= w_pnd;
            r_msk    <= w_msk;
            r_vec    <= w_vec_hit;
            DEV_Addr <= PrAddr[3:2];
            DEV_WD   <= PrWD;
            We0      <= PrWe & w_t0;
            We1      <= PrWe & w_t1;
          end
        end
        S_ACCESS: begin
          r_state <= S_DONE;
          if (!r_we) PrRD <= w_rdata;
          if (r_we && r_msk) r_mask <= DEV_WD[NSRC-1:0];
        end
        S_DONE: begin
          r_state <= S_IDLE;
          PrReady <= 1'b1;
          PrErr   <= ~(r_t0 | r_t1 | r_pnd | r_msk | r_vec);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef DEV_BRIDGE_EDGE_EN
  logic [NSRC-1:0] r_hist;
  logic [NSRC-1:0] w_clr;

  assign w_clr = (r_state == S_ACCESS && r_we && r_pnd) ? DEV_WD[NSRC-1:0] : '0;

  // Rising edges set; W1C clears, but a coincident set wins
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist <= '0;
      r_pend <= '0;
    end else begin
      r_hist <= w_src;
      r_pend <= (r_pend & ~w_clr) | (w_src & ~r_hist);
    end
  end
`else
  // Level mode: pending bits mirror the sources every cycle
  always_ff @(posedge clk) begin
    if (reset) r_pend <= '0;
    else       r_pend <= w_src;
  end
`endif

endmodule

// File: tb/tb_dev_bridge.sv
// Directed bench for dev_bridge: timer windows, interrupt controller, unmapped and reset-abort cases.
// Mode-dependent expectations follow DEV_BRIDGE_EDGE_EN.
module tb_dev_bridge;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk = 1'b0;
  logic        reset;
  logic        PrReq;
  logic [31:0] PrAddr;
  logic        PrWe;
  logic [31:0] PrWD;
  logic [31:0] PrRD;
  logic        PrReady;
  logic        PrErr;
  logic [1:0]  DEV_Addr;
  logic [31:0] DEV_WD;
  logic        We0, We1;
  logic [31:0] RD0, RD1;
  logic        break0, break1;
  logic [3:0]  ext_irq;
  logic [5:0]  HWInt;

  int n_pass  = 0;
  int n_total = 0;

  dev_bridge #(.BASE(BASE)) dut (
    .clk(clk), .reset(reset),
    .PrReq(PrReq), .PrAddr(PrAddr), .PrWe(PrWe), .PrWD(PrWD),
    .PrRD(PrRD), .PrReady(PrReady), .PrErr(PrErr),
    .DEV_Addr(DEV_Addr), .DEV_WD(DEV_WD), .We0(We0), .We1(We1),
    .RD0(RD0), .RD1(RD1), .break0(break0), .break1(break1),
    .ext_irq(ext_irq), .HWInt(HWInt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Full access: request accepted at the first edge, PrReady visible after the third
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    PrReq = 1'b1; PrWe = we; PrAddr = addr; PrWD = wd;
    tick();
    PrReq = 1'b0;
    tick();
    tick();
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    access(1'b0, addr, 32'd0);
    check({tag, "_rdy"}, {31'd0, PrReady}, 32'd1);
    check({tag, "_err"}, {31'd0, PrErr}, 32'd0);
    check(tag, PrRD, exp);
  endtask

  initial begin
    reset = 1'b1; PrReq = 1'b0; PrAddr = '0; PrWe = 1'b0; PrWD = '0;
    RD0 = '0; RD1 = '0; break0 = 1'b0; break1 = 1'b0; ext_irq = '0;
    tick(); tick();
    check("rst_prrd",  PrRD, 32'd0);
    check("rst_ready", {31'd0, PrReady}, 32'd0);
    check("rst_err",   {31'd0, PrErr}, 32'd0);
    check("rst_we",    {30'd0, We1, We0}, 32'd0);
    check("rst_hwint", {26'd0, HWInt}, 32'd0);
    reset = 1'b0;
    tick();

    // Timer0 write pulse and fixed latency
    PrReq = 1'b1; PrWe = 1'b1; PrAddr = BASE; PrWD = 32'h9;
    tick();
    PrReq = 1'b0;
    check("t0w_we0",   {31'd0, We0}, 32'd1);
    check("t0w_we1",   {31'd0, We1}, 32'd0);
    check("t0w_daddr", {30'd0, DEV_Addr}, 32'd0);
    check("t0w_dwd",   DEV_WD, 32'h9);
    check("t0w_rdy0",  {31'd0, PrReady}, 32'd0);
    tick();
    check("t0w_we0_off", {31'd0, We0}, 32'd0);
    check("t0w_rdy1",    {31'd0, PrReady}, 32'd0);
    tick();
    check("t0w_rdy", {31'd0, PrReady}, 32'd1);
    check("t0w_err", {31'd0, PrErr}, 32'd0);
    tick();
    check("t0w_rdy_pulse", {31'd0, PrReady}, 32'd0);

    // Timer1 read at offset 0x18
    RD1 = 32'h1234; RD0 = 32'hABCD;
    PrReq = 1'b1; PrWe = 1'b0; PrAddr = BASE + 32'h18;
    tick();
    PrReq = 1'b0;
    check("t1r_daddr", {30'd0, DEV_Addr}, 32'd2);
    check("t1r_we",    {30'd0, We1, We0}, 32'd0);
    tick(); tick();
    check("t1r_rdy", {31'd0, PrReady}, 32'd1);
    check("t1r_rd",  PrRD, 32'h1234);
    read_chk("t0r_04", BASE + 32'h04, 32'hABCD);

    // Timer1 write pulses We1 only
    PrReq = 1'b1; PrWe = 1'b1; PrAddr = BASE + 32'h14; PrWD = 32'h5;
    tick();
    PrReq = 1'b0;
    check("t1w_we", {30'd0, We1, We0}, 32'd2);
    check("t1w_daddr", {30'd0, DEV_Addr}, 32'd1);
    tick(); tick();

    // Interrupt controller
    access(1'b1, BASE + 32'h24, 32'h3F);
    check("msk_hw0", {26'd0, HWInt}, 32'd0);
    read_chk("msk_rd", BASE + 32'h24, 32'h3F);
    read_chk("msk_rd_lowbits", BASE + 32'h26, 32'h3F);
    break1 = 1'b1; ext_irq = 4'h1;
    tick();
    check("irq_hw", {26'd0, HWInt}, 32'h06);
    read_chk("pend_rd", BASE + 32'h20, 32'h06);
    read_chk("vec_rd1", BASE + 32'h28, 32'h8000_0001);
    access(1'b1, BASE + 32'h20, 32'h2);
    check("w1c_err", {31'd0, PrErr}, 32'd0);
`ifdef DEV_BRIDGE_EDGE_EN
    read_chk("vec_after_w1c", BASE + 32'h28, 32'h8000_0002);
`else
    read_chk("vec_after_w1c", BASE + 32'h28, 32'h8000_0001);
`endif
    break1 = 1'b0;
    tick();
    read_chk("vec_rd2", BASE + 32'h28, 32'h8000_0002);
    check("irq_hw2", {26'd0, HWInt}, 32'h04);
    access(1'b1, BASE + 32'h24, 32'h01);
    check("msk1_hw", {26'd0, HWInt}, 32'd0);
    read_chk("vec_none", BASE + 32'h28, 32'd0);
    access(1'b1, BASE + 32'h28, 32'hFFFF_FFFF);
    check("vec_wr_err", {31'd0, PrErr}, 32'd0);
    access(1'b1, BASE + 32'h24, 32'h3F);

    // Held break0 and W1C behaviour
    break0 = 1'b1;
    tick();
    read_chk("b0_pend", BASE + 32'h20, 32'h05);
    access(1'b1, BASE + 32'h20, 32'h01);
    tick(); tick(); tick();
`ifdef DEV_BRIDGE_EDGE_EN
    read_chk("b0_held", BASE + 32'h20, 32'h04);
`else
    read_chk("b0_held", BASE + 32'h20, 32'h05);
`endif
    break0 = 1'b0;
    tick();
    break0 = 1'b1;
    tick();
    read_chk("b0_rearm", BASE + 32'h20, 32'h05);
    break0 = 1'b0; ext_irq = 4'h0;

    // Back-to-back requests with PrReq held high
    PrReq = 1'b1; PrWe = 1'b0; PrAddr = BASE + 32'h24;
    tick(); tick(); tick();
    check("b2b_rdy1", {31'd0, PrReady}, 32'd1);
    tick();
    check("b2b_gap1", {31'd0, PrReady}, 32'd0);
    tick();
    check("b2b_gap2", {31'd0, PrReady}, 32'd0);
    tick();
    check("b2b_rdy2", {31'd0, PrReady}, 32'd1);
    PrReq = 1'b0;
    tick(); tick(); tick();

    // Unmapped addresses
    access(1'b0, BASE + 32'h30, 32'd0);
    check("unm30_rdy", {31'd0, PrReady}, 32'd1);
    check("unm30_err", {31'd0, PrErr}, 32'd1);
    check("unm30_rd",  PrRD, 32'd0);
    read_chk("mask_again", BASE + 32'h24, 32'h3F);
    access(1'b0, BASE + 32'h40, 32'd0);
    check("unm40_err", {31'd0, PrErr}, 32'd1);
    check("unm40_rd",  PrRD, 32'd0);
    PrReq = 1'b1; PrWe = 1'b1; PrAddr = BASE + 32'h0C; PrWD = 32'h1;
    tick();
    PrReq = 1'b0;
    check("unm0c_we", {30'd0, We1, We0}, 32'd0);
    tick(); tick();
    check("unm0c_err", {31'd0, PrErr}, 32'd1);

    // Reset during ACCESS aborts the write
    PrReq = 1'b1; PrWe = 1'b1; PrAddr = BASE + 32'h08; PrWD = 32'h7;
    tick();
    PrReq = 1'b0;
    check("abort_daddr_pre", {30'd0, DEV_Addr}, 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_we",    {30'd0, We1, We0}, 32'd0);
    check("abort_rdy",   {31'd0, PrReady}, 32'd0);
    check("abort_daddr", {30'd0, DEV_Addr}, 32'd0);
    check("abort_dwd",   DEV_WD, 32'd0);
    check("abort_prrd",  PrRD, 32'd0);
    check("abort_err",   {31'd0, PrErr}, 32'd0);
    tick();
    check("abort_we2",  {30'd0, We1, We0}, 32'd0);
    check("abort_rdy2", {31'd0, PrReady}, 32'd0);
    tick();
    check("abort_rdy3", {31'd0, PrReady}, 32'd0);
    tick();
    check("abort_rdy4", {31'd0, PrReady}, 32'd0);
    read_chk("abort_mask", BASE + 32'h24, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
